// File: rtl/printer_pkg.sv
// Shared types and constants for the office printer scheduler.
package printer_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, PRINT, DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_BOSS = 2'b01;
  localparam logic [1:0] OWN_ENG  = 2'b10;
  localparam logic [1:0] OWN_BOY  = 2'b11;

  // Bit positions in the request vector; lower index means higher priority.
  localparam int REQ_BOSS = 0;
  localparam int REQ_ENG  = 1;
  localparam int REQ_BOY  = 2;

  function automatic logic [1:0] own_code(input int idx);
    return 2'(idx + 1);
  endfunction

endpackage

// File: rtl/printer_age_arb.sv
// Per-requester wait counters with aging promotion, plus the fixed-priority winner select.
module printer_age_arb
  import printer_pkg::*;
#(
  parameter int AGE_MAX = 8,
  parameter int CW      = $clog2(AGE_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [1:0] owner,
  input  logic       grant,
  output logic [1:0] winner,
  output logic       valid
);

  localparam logic [CW-1:0] AGE_TOP = CW'(AGE_MAX);

  logic [2:0] aged;
  logic [2:0] pool;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_wait
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt <= '0;
        end else if (!req[gi] || owner == own_code(gi) ||
                     (grant && winner == own_code(gi))) begin
          cnt <= '0;
        end else if (cnt != AGE_TOP) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign aged[gi] = req[gi] && (cnt == AGE_TOP);
    end
  endgenerate

  // Aged requesters form their own pool; priority order applies within whichever pool is used.
  assign pool  = (|aged) ? aged : req;
  assign valid = |req;

  always_comb begin
    winner = OWN_NONE;
    if (pool[REQ_BOSS])     winner = OWN_BOSS;
    else if (pool[REQ_ENG]) winner = OWN_ENG;
    else if (pool[REQ_BOY]) winner = OWN_BOY;
  end

endmodule

// File: rtl/printer_sched.sv
// Printer ownership scheduler: arbitrates three requesters and tracks a multi-page job
// until completion, owner abort, or inter-page timeout.
module printer_sched
  import printer_pkg::*;
#(
  parameter int PW      = 4,
  parameter int AGE_MAX = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rboss,
  input  logic          reng,
  input  logic          rboy,
  input  logic [3*PW-1:0] pages,
  input  logic          page_done,
  output logic [1:0]    usingby,
  output logic          start,
  output logic          done,
  output logic          abort,
  output logic          fault
);

  localparam int            TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        state;
  logic [1:0]    owner;
  logic [PW-1:0] pages_left;
  logic [TW-1:0] timer;

  logic [2:0]    req;
  logic [1:0]    winner;
  logic          win_valid;
  logic          grant;
  logic [1:0]    arb_owner;
  logic          owner_req;
  logic [PW-1:0] owner_pages;

  assign req       = {rboy, reng, rboss};
  assign grant     = (state == IDLE) && win_valid;
  // The stale owner of the previous job must not pin its counter while idle.
  assign arb_owner = (state == IDLE) ? OWN_NONE : owner;

  always_comb begin
    owner_req   = 1'b0;
    owner_pages = '0;
    case (owner)
      OWN_BOSS: begin owner_req = rboss; owner_pages = pages[3*PW-1:2*PW]; end
      OWN_ENG:  begin owner_req = reng;  owner_pages = pages[2*PW-1:PW];   end
      OWN_BOY:  begin owner_req = rboy;  owner_pages = pages[PW-1:0];      end
      default:  ;
    endcase
  end

  printer_age_arb #(.AGE_MAX(AGE_MAX)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .owner  (arb_owner),
    .grant  (grant),
    .winner (winner),
    .valid  (win_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      pages_left <= '0;
      timer      <= '0;
      usingby    <= OWN_NONE;
      start      <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      abort <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          usingby <= OWN_NONE;
          if (win_valid) begin
            owner <= winner;
            state <= GRANT;
          end
        end
        GRANT: begin
          usingby    <= owner;
          start      <= 1'b1;
          pages_left <= (owner_pages == '0) ? PW'(1) : owner_pages;
          timer      <= '0;
          state      <= PRINT;
        end
        PRINT: begin
          usingby <= owner;
          if (!owner_req) begin
            abort   <= 1'b1;
            done    <= 1'b1;
            usingby <= OWN_NONE;
            state   <= DONE;
          end else if (page_done && pages_left == PW'(1)) begin
            done    <= 1'b1;
            usingby <= OWN_NONE;
            state   <= DONE;
          end else if (page_done) begin
            pages_left <= pages_left - 1'b1;
            timer      <= '0;
          end else if (timer == TMAX) begin
            fault   <= 1'b1;
            done    <= 1'b1;
            usingby <= OWN_NONE;
            state   <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          usingby <= OWN_NONE;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/printer_sched.md
Name: printer_sched

Overview:
- Scheduler for the shared office printer. Arbitrates three requesters: boss, engineer, boy.
- Fixed priority boss > eng > boy, with aging promotion so a low-priority requester cannot starve.
- Owns the printer for a whole multi-page job, counts completed pages, and releases ownership on job completion, requester abort or page timeout.
- Sits between the requester request lines and the printer datapath (start/page_done handshake).

Parameters:
- PW, 4: width of each page-count field.
- AGE_MAX, 8: cycles a requester may wait before it is promoted. Wait counter width is $clog2(AGE_MAX+1).
- TIMEOUT, 16: maximum cycles between page_done pulses before a fault.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rboss  in  1  boss request (level).
- reng  in  1  engineer request (level).
- rboy  in  1  boy request (level).
- pages  in  3*PW  requested page count per requester: [3*PW-1:2*PW] boss, [2*PW-1:PW] eng, [PW-1:0] boy. Sampled only in GRANT.
- page_done  in  1  one-cycle pulse from the printer per finished page.
- usingby  out  2  current owner: 00 none, 01 boss, 10 eng, 11 boy.
- start  out  1  one-cycle pulse telling the printer to begin the job.
- done  out  1  one-cycle pulse at job release.
- abort  out  1  high with done when the owner dropped its request.
- fault  out  1  high with done when the page timeout expired.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; usingby, start, done, abort, fault = 0; all wait counters, pages_left and page timer = 0.
- Wait counters, one per requester:
  - Increment each cycle the requester's line is high and it is not the owner; saturate at AGE_MAX.
  - Clear when the line is low, or in the cycle the requester is granted.
- A requester is "aged" when its counter equals AGE_MAX.
- IDLE:
  - usingby=00.
  - If any request is high: winner = highest-priority aged requester if any are aged, otherwise highest-priority requester. Register the winner as owner; go to GRANT.
  - If no request is high, stay in IDLE.
- GRANT (1 cycle):
  - usingby=owner code; start=1.
  - pages_left = owner's pages field; a value of 0 is treated as 1.
  - Page timer cleared; go to PRINT.
  - Latency: request sampled high in IDLE at edge k → usingby and start valid in the cycle after edge k+1.
- PRINT:
  - usingby=owner code.
  - Page timer increments each cycle and clears on page_done.
  - Exit checks, in priority order:
    1. Owner request low → abort=1 at the DONE entry, go to DONE.
    2. page_done with pages_left==1 → go to DONE.
    3. page_done otherwise → pages_left decrements.
    4. Timer reaches TIMEOUT-1 with no page_done → fault=1, go to DONE.
  - If page_done and the owner's drop occur in the same cycle, abort wins.
  - Requests from other requesters never preempt the owner.
- DONE (1 cycle):
  - usingby=00; done=1; abort/fault as latched.
  - Owner wait counter held at 0; go to IDLE.
  - Consequence: there is always at least one idle cycle between back-to-back jobs.
- page_done outside PRINT is ignored.
- abort and fault are mutually exclusive.
- Mid-operation reset: an asynchronous reset in any state returns to IDLE immediately. No done pulse is issued.

Decomposition:
- Shared package printer_pkg holds:
  - state enum (IDLE, GRANT, PRINT, DONE);
  - owner codes OWN_NONE/BOSS/ENG/BOY;
  - requester index constants.
- One natural sub-module: printer_age_arb. It contains the three wait counters and the combinational winner select. Inputs: req vector, owner, grant strobe. Outputs: winner code and a valid flag.
- The FSM, page counter and timer stay in the top module.

Test Plan:
- Reset then rboss=reng=rboy=1 with pages boss=2. Expect usingby=01 and start one cycle after IDLE sampling. After two page_done pulses, expect a done pulse and usingby=00 for one cycle. Engineer is granted next.
- rboy=1 held throughout; rboss is toggled on for jobs of 1 page each with page_done every 3 cycles. Once the boy's counter reaches 8, the boy wins the next IDLE over the boss: usingby=11.
- reng alone with pages=3. After one page_done, drop reng. Expect done=1 and abort=1 in the same cycle, then usingby=00.
- rboss with pages=1 and no page_done. Exactly 16 cycles after entering PRINT, expect fault=1 with done=1 and usingby returning to 00.
- rboy with pages=0. Expect the job to end after a single page_done.
- Assert rst=0 asynchronously mid-PRINT. Expect all outputs 0 before the next clock edge, then a fresh grant after release.
